// File: rtl/debug_controller.sv
// Host debug controller: sequences processor reset and the wait/continue
// handshake, reads debug registers, and shares the data-memory port with the host.
module debug_controller #(
  parameter int ADDR_SIZE    = 18,
  parameter int WORD_SIZE    = 18,
  parameter int RESET_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 host_cmd_valid,
  output logic                 host_cmd_ready,
  input  logic [2:0]           host_cmd,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_rsp_valid,
  output logic                 host_rsp_error,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 host_halted,
  output logic                 proc_reset,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out,
  input  logic                 cpu_mem_we,
  input  logic [ADDR_SIZE-1:0] cpu_mem_addr,
  input  logic [WORD_SIZE-1:0] cpu_mem_din,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_din,
  input  logic [WORD_SIZE-1:0] mem_dout
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_RESET_CPU = 3'd1;
  localparam logic [2:0] CMD_RUN       = 3'd2;
  localparam logic [2:0] CMD_READ_REG  = 3'd3;
  localparam logic [2:0] CMD_READ_MEM  = 3'd4;
  localparam logic [2:0] CMD_WRITE_MEM = 3'd5;

  typedef enum logic [3:0] {
    S_RESET_HOLD, S_IDLE, S_REG_RD, S_MEM_A, S_MEM_D,
    S_MEM_W, S_RUN_PULSE, S_RUN_WAIT, S_RSP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   pend_q, pend_d;
  logic                   halted_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RESET_HOLD;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      halted_q <= wait_for_continue;
    end
  end

  always_comb begin
    state_d                 = state_q;
    cnt_d                   = cnt_q;
    addr_d                  = addr_q;
    wdata_d                 = wdata_q;
    rdata_d                 = rdata_q;
    err_d                   = err_q;
    pend_d                  = pend_q;
    host_cmd_ready          = 1'b0;
    host_rsp_valid          = 1'b0;
    host_rsp_error          = 1'b0;
    proc_reset              = 1'b0;
    wait_continue_execution = 1'b0;
    debug_get_param         = 1'b0;
    debug_reg_addr          = 4'd0;
    mem_we                  = cpu_mem_we;
    mem_addr                = cpu_mem_addr;
    mem_din                 = cpu_mem_din;

    case (state_q)
      S_RESET_HOLD: begin
        proc_reset = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = pend_q ? S_RSP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        host_cmd_ready = 1'b1;
        if (host_cmd_valid) begin
          addr_d  = host_addr;
          wdata_d = host_wdata;
          err_d   = 1'b0;
          // Halt state is judged only here; later changes cannot abort the op.
          case (host_cmd)
            CMD_NOP:       state_d = S_RSP;
            CMD_RESET_CPU: begin
              pend_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_RESET_HOLD;
            end
            CMD_RUN, CMD_READ_REG, CMD_READ_MEM, CMD_WRITE_MEM: begin
              if (!wait_for_continue) begin
                err_d   = 1'b1;
                state_d = S_RSP;
              end else if (host_cmd == CMD_RUN) begin
                state_d = S_RUN_PULSE;
              end else if (host_cmd == CMD_READ_REG) begin
                state_d = S_REG_RD;
              end else if (host_cmd == CMD_READ_MEM) begin
                state_d = S_MEM_A;
              end else begin
                state_d = S_MEM_W;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_RSP;
            end
          endcase
        end
      end
      S_REG_RD: begin
        debug_get_param = 1'b1;
        debug_reg_addr  = addr_q[3:0];
        rdata_d         = debug_data_out;
        state_d         = S_RSP;
      end
      S_MEM_A: begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = wdata_q;
        state_d  = S_MEM_D;
      end
      S_MEM_D: begin
        // Address stays on the port while the ram's registered output settles.
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = wdata_q;
        rdata_d  = mem_dout;
        state_d  = S_RSP;
      end
      S_MEM_W: begin
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_din  = wdata_q;
        state_d  = S_RSP;
      end
      S_RUN_PULSE: begin
        wait_continue_execution = 1'b1;
        state_d                 = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (!wait_for_continue) state_d = S_RSP;
      end
      S_RSP: begin
        host_rsp_valid = 1'b1;
        host_rsp_error = err_q;
        pend_d         = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_RESET_HOLD;
    endcase
  end

  assign host_rdata  = rdata_q;
  assign host_halted = halted_q;

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller with a small processor/ram model:
// table of host commands with hand-computed responses, plus run and reset sequences.
module tb_debug_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_cmd_valid = 1'b0;
  logic        host_cmd_ready;
  logic [2:0]  host_cmd = 3'd0;
  logic [17:0] host_addr = '0;
  logic [17:0] host_wdata = '0;
  logic        host_rsp_valid, host_rsp_error;
  logic [17:0] host_rdata;
  logic        host_halted, proc_reset;
  logic        wait_for_continue;
  logic        wait_continue_execution;
  logic        debug_get_param;
  logic [3:0]  debug_reg_addr;
  logic [17:0] debug_data_out;
  logic        cpu_mem_we = 1'b0;
  logic [17:0] cpu_mem_addr = 18'h00040;
  logic [17:0] cpu_mem_din = 18'h00000;
  logic        mem_we;
  logic [17:0] mem_addr, mem_din;
  logic [17:0] mem_dout;

  debug_controller #(.ADDR_SIZE(18), .WORD_SIZE(18), .RESET_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd(host_cmd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_error(host_rsp_error),
    .host_rdata(host_rdata), .host_halted(host_halted), .proc_reset(proc_reset),
    .wait_for_continue(wait_for_continue),
    .wait_continue_execution(wait_continue_execution),
    .debug_get_param(debug_get_param), .debug_reg_addr(debug_reg_addr),
    .debug_data_out(debug_data_out),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  // Processor model: halted when halt_en, runs 6 cycles after a continue pulse.
  logic       halt_en = 1'b0;
  logic       proc_stuck = 1'b0;
  logic [3:0] run_cnt = 4'd0;
  always @(posedge clock) begin
    if (wait_continue_execution && !proc_stuck) run_cnt <= 4'd6;
    else if (run_cnt != 4'd0) run_cnt <= run_cnt - 4'd1;
  end
  assign wait_for_continue = halt_en && (run_cnt == 4'd0) && !(proc_stuck && 1'b0);

  function automatic logic [17:0] dbg_val(input logic [3:0] idx);
    if (idx == 4'd8) return 18'h00ABC;
    return 18'h01000 + 18'h00111 * {14'd0, idx};
  endfunction
  assign debug_data_out = debug_get_param ? dbg_val(debug_reg_addr) : 18'h00000;

  logic [17:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_din;
    mem_dout <= ram[mem_addr[7:0]];
  end

  int gp_cnt = 0, mux_cnt = 0, prc_cnt = 0, cont_cnt = 0, rsp_cnt = 0;
  always @(negedge clock) begin
    if (debug_get_param) gp_cnt <= gp_cnt + 1;
    if (mem_we !== cpu_mem_we || mem_addr !== cpu_mem_addr || mem_din !== cpu_mem_din)
      mux_cnt <= mux_cnt + 1;
    if (proc_reset) prc_cnt <= prc_cnt + 1;
    if (wait_continue_execution) cont_cnt <= cont_cnt + 1;
    if (host_rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] cmd, input logic [17:0] addr, input logic [17:0] wdata,
                        output logic err, output logic [17:0] rdata, output int lat,
                        output int gp, output int mux, output int prc, output int cont,
                        output logic halted);
    int w, g0, m0, p0, c0;
    w = 0;
    @(negedge clock);
    while (!host_cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 32'(w), 32'd0);
    g0 = gp_cnt; m0 = mux_cnt; p0 = prc_cnt; c0 = cont_cnt;
    host_cmd_valid = 1'b1;
    host_cmd = cmd;
    host_addr = addr;
    host_wdata = wdata;
    @(negedge clock);
    host_cmd_valid = 1'b0;
    lat = 0;
    while (!host_rsp_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    err = host_rsp_error;
    rdata = host_rdata;
    halted = host_halted;
    gp = gp_cnt - g0; mux = mux_cnt - m0; prc = prc_cnt - p0; cont = cont_cnt - c0;
  endtask

  // Releases reset just after a rising edge and counts full cycles of proc_reset.
  task automatic release_and_count(input string tag);
    int n, r0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    r0 = rsp_cnt;
    n = 0;
    @(negedge clock);
    while (proc_reset && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_proc_reset_cycles"}, 32'(n), 32'd4);
    chk({tag, "_ready_after_hold"}, 32'(host_cmd_ready), 32'd1);
    chk({tag, "_no_response"}, 32'(rsp_cnt - r0 + (host_rsp_valid ? 1 : 0)), 32'd0);
  endtask

  typedef struct {
    logic halt; logic [2:0] cmd; logic [17:0] addr; logic [17:0] wdata;
    logic err; logic [17:0] rdata; int lat; int gp; int mux; int prc;
  } vec_t;
  vec_t vecs [18];

  logic        r_err, r_halted;
  logic [17:0] r_rdata;
  int          r_lat, r_gp, r_mux, r_prc, r_cont;

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 18'h00008, 18'h00000, 1'b0, 18'h00ABC, 1, 1, 0, 0};
    vecs[1]  = '{1'b1, 3'd3, 18'h00003, 18'h00000, 1'b0, 18'h01333, 1, 1, 0, 0};
    vecs[2]  = '{1'b1, 3'd5, 18'h00005, 18'h2ABCD, 1'b0, 18'h01333, 1, 0, 1, 0};
    vecs[3]  = '{1'b1, 3'd4, 18'h00005, 18'h00000, 1'b0, 18'h2ABCD, 2, 0, 2, 0};
    vecs[4]  = '{1'b0, 3'd4, 18'h00000, 18'h00000, 1'b1, 18'h2ABCD, 0, 0, 0, 0};
    vecs[5]  = '{1'b0, 3'd5, 18'h00005, 18'h11111, 1'b1, 18'h2ABCD, 0, 0, 0, 0};
    vecs[6]  = '{1'b1, 3'd4, 18'h00005, 18'h00000, 1'b0, 18'h2ABCD, 2, 0, 2, 0};
    vecs[7]  = '{1'b1, 3'd0, 18'h00000, 18'h00000, 1'b0, 18'h2ABCD, 0, 0, 0, 0};
    vecs[8]  = '{1'b0, 3'd0, 18'h00000, 18'h00000, 1'b0, 18'h2ABCD, 0, 0, 0, 0};
    vecs[9]  = '{1'b0, 3'd2, 18'h00000, 18'h00000, 1'b1, 18'h2ABCD, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 3'd3, 18'h00003, 18'h00000, 1'b1, 18'h2ABCD, 0, 0, 0, 0};
    vecs[11] = '{1'b1, 3'd6, 18'h00000, 18'h00000, 1'b1, 18'h2ABCD, 0, 0, 0, 0};
    vecs[12] = '{1'b1, 3'd3, 18'h0000C, 18'h00000, 1'b0, 18'h01CCC, 1, 1, 0, 0};
    vecs[13] = '{1'b1, 3'd5, 18'h3FFFF, 18'h3FFFF, 1'b0, 18'h01CCC, 1, 0, 1, 0};
    vecs[14] = '{1'b1, 3'd4, 18'h3FFFF, 18'h00000, 1'b0, 18'h3FFFF, 2, 0, 2, 0};
    vecs[15] = '{1'b1, 3'd1, 18'h00000, 18'h00000, 1'b0, 18'h3FFFF, 4, 0, 0, 4};
    vecs[16] = '{1'b0, 3'd1, 18'h00000, 18'h00000, 1'b0, 18'h3FFFF, 4, 0, 0, 4};
    vecs[17] = '{1'b1, 3'd7, 18'h00000, 18'h00000, 1'b1, 18'h3FFFF, 0, 0, 0, 0};

    // Reset values while reset_n is held low.
    repeat (3) @(negedge clock);
    chk("rst_proc_reset", 32'(proc_reset), 32'd1);
    chk("rst_ready", 32'(host_cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_halted", 32'(host_halted), 32'd0);
    chk("rst_mux_passthrough", 32'(mem_addr), 32'(cpu_mem_addr));
    chk("rst_continue", 32'(wait_continue_execution), 32'd0);
    release_and_count("poweron");

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      halt_en = vecs[i].halt;
      @(negedge clock);
      do_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
             r_err, r_rdata, r_lat, r_gp, r_mux, r_prc, r_cont, r_halted);
      chk($sformatf("v%0d_error", i), 32'(r_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_rdata", i), 32'(r_rdata), 32'(vecs[i].rdata));
      chk($sformatf("v%0d_get_param_cycles", i), 32'(r_gp), 32'(vecs[i].gp));
      chk($sformatf("v%0d_mux_cycles", i), 32'(r_mux), 32'(vecs[i].mux));
      chk($sformatf("v%0d_proc_reset_cycles", i), 32'(r_prc), 32'(vecs[i].prc));
      chk($sformatf("v%0d_continue_pulses", i), 32'(r_cont), 32'd0);
      chk($sformatf("v%0d_halted", i), 32'(r_halted), 32'(vecs[i].halt));
    end

    // RUN while halted: one pulse, response once the processor resumes, then re-halt.
    @(negedge clock);
    halt_en = 1'b1;
    @(negedge clock);
    do_cmd(3'd2, 18'h00000, 18'h00000, r_err, r_rdata, r_lat, r_gp, r_mux, r_prc, r_cont, r_halted);
    chk("run_error", 32'(r_err), 32'd0);
    chk("run_latency", 32'(r_lat), 32'd2);
    chk("run_continue_pulses", 32'(r_cont), 32'd1);
    chk("run_halted_at_rsp", 32'(r_halted), 32'd0);
    repeat (10) @(negedge clock);
    chk("run_rehalted", 32'(host_halted), 32'd1);

    // Reset asserted while stuck in RUN_WAIT: no response, hold sequence restarts.
    proc_stuck = 1'b1;
    @(negedge clock);
    run_cnt_force_wait();
    proc_stuck = 1'b0;

    do_cmd(3'd7, 18'h00000, 18'h00000, r_err, r_rdata, r_lat, r_gp, r_mux, r_prc, r_cont, r_halted);
    chk("after_reset_cmd7_error", 32'(r_err), 32'd1);
    chk("after_reset_cmd7_latency", 32'(r_lat), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Drives RUN with the processor model refusing to resume, then pulls reset_n.
  task automatic run_cnt_force_wait();
    int r0;
    halt_en = 1'b1;
    @(negedge clock);
    host_cmd_valid = 1'b1;
    host_cmd = 3'd2;
    @(negedge clock);
    host_cmd_valid = 1'b0;
    r0 = rsp_cnt;
    @(negedge clock);
    @(negedge clock);
    chk("stuck_no_response", 32'(host_rsp_valid), 32'd0);
    chk("stuck_still_halted_input", 32'(wait_for_continue), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midop_proc_reset", 32'(proc_reset), 32'd1);
    chk("midop_ready", 32'(host_cmd_ready), 32'd0);
    chk("midop_rdata", 32'(host_rdata), 32'd0);
    repeat (2) @(negedge clock);
    chk("midop_no_response", 32'(rsp_cnt - r0), 32'd0);
    release_and_count("midop");
  endtask

endmodule
